// File: rtl/fdiv_arbiter.sv
// fdiv_arbiter: shares one fixed-latency fdiv pipeline between two requesters.
// Round-robin grant with per-port credit, a tag shift register that follows
// each operation through the pipe, and a per-port in-order result FIFO.
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-port request handshake (req_ready = grant)
//   req_x1/req_x2         packed operands, port i at [32i+31:32i]
//   resp_valid/resp_ready per-port result handshake
//   resp_y                packed FIFO heads, same packing
//   div_x1/div_x2/div_y   shared fdiv operands and quotient
//   busy                  any op in flight or any result queued
module fdiv_arbiter #(
    parameter int unsigned LAT   = 7,
    parameter int unsigned DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_x1,
    input  logic [63:0] req_x2,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [63:0] resp_y,
    output logic [31:0] div_x1,
    output logic [31:0] div_x2,
    input  logic [31:0] div_y,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]  inflight [2];
    logic [CW-1:0]  count    [2];
    logic [PW-1:0]  wr_ptr   [2];
    logic [PW-1:0]  rd_ptr   [2];
    logic [31:0]    mem      [2][DEPTH];
    logic           rr;
    logic [LAT-1:0] tag_valid;
    logic [LAT-1:0] tag_port;
    logic [1:0]     eligible;
    logic [1:0]     grant;
    logic [1:0]     retire;
    logic [1:0]     pop;

    // Credit check uses start-of-cycle occupancy, so a pop this cycle frees nothing yet.
    always_comb begin
        eligible = 2'b00;
        for (int i = 0; i < 2; i++) begin
            eligible[i] = rst_n && req_valid[i] &&
                          ((SW'(inflight[i]) + SW'(count[i])) < SW'(DEPTH));
        end
    end

    // One grant per cycle; rr only breaks ties.
    always_comb begin
        grant = 2'b00;
        case (eligible)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = rr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign req_ready = grant;

    // Operand mux toward the shared divider.
    always_comb begin
        div_x1 = 32'h0;
        div_x2 = 32'h0;
        if (grant[0]) begin
            div_x1 = req_x1[31:0];
            div_x2 = req_x2[31:0];
        end else if (grant[1]) begin
            div_x1 = req_x1[63:32];
            div_x2 = req_x2[63:32];
        end
    end

    // Retire and pop strobes per port.
    always_comb begin
        retire = 2'b00;
        pop    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            retire[i] = tag_valid[LAT-1] && (tag_port[LAT-1] == 1'(i));
            pop[i]    = (count[i] != '0) && resp_ready[i];
        end
    end

    // Result view and activity flag, all derived from registered state.
    always_comb begin
        resp_valid = 2'b00;
        resp_y     = 64'h0;
        busy       = 1'b0;
        for (int i = 0; i < 2; i++) begin
            resp_valid[i]    = (count[i] != '0);
            resp_y[32*i +: 32] = mem[i][rd_ptr[i]];
            if ((inflight[i] != '0) || (count[i] != '0)) begin
                busy = 1'b1;
            end
        end
    end

    // Arbitration pointer, tag pipe, credit counters and FIFO pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr        <= 1'b0;
            tag_valid <= '0;
            tag_port  <= '0;
            for (int i = 0; i < 2; i++) begin
                inflight[i] <= '0;
                count[i]    <= '0;
                wr_ptr[i]   <= '0;
                rd_ptr[i]   <= '0;
            end
        end else begin
            if (grant[0]) begin
                rr <= 1'b1;
            end else if (grant[1]) begin
                rr <= 1'b0;
            end

            tag_valid[0] <= |grant;
            tag_port[0]  <= grant[1];
            for (int k = 1; k < LAT; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_port[k]  <= tag_port[k-1];
            end

            for (int i = 0; i < 2; i++) begin
                if (grant[i] && !retire[i]) begin
                    inflight[i] <= inflight[i] + CW'(1);
                end else if (!grant[i] && retire[i]) begin
                    inflight[i] <= inflight[i] - CW'(1);
                end

                if (retire[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!retire[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end

                if (retire[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == PW'(DEPTH - 1)) ? '0 : rd_ptr[i] + PW'(1);
                end
            end
        end
    end

    // FIFO storage; quotient is written untouched, whatever its value.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (retire[i]) begin
                mem[i][wr_ptr[i]] <= div_y;
            end
        end
    end

    // Credit rule guarantees a free slot for every retiring result.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_n && retire[i]) begin
                assert (count[i] != CW'(DEPTH));
            end
        end
    end

endmodule
